uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
- Frame-level controller for the UART transmit path.
- Owns the baud-rate divider: a runtime-programmable divisor counter, gated so it runs only while a frame is in flight.
- Sequences start, data, optional parity and stop bits onto the serial line.
- Accepts bytes from the host logic over a valid/ready handshake; sits between the user-side byte source and the FPGA TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- DIV_W, 16, width of the divisor register and baud counter.
- DIV_RESET, 434, divisor after reset, in clocks per bit (115200 baud at 50 MHz).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to send; sampled on the accept cycle.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  sequencer idle and able to accept a byte.
- div_wr  in  1  one-cycle strobe: load div_val as the new divisor.
- div_val  in  DIV_W  requested clocks-per-bit.
- div_cur  out  DIV_W  divisor currently in effect.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, tx_ready=1, busy=0, frame_done=0, div_cur=DIV_RESET.
  - Any pending divisor write is cleared; the baud counter is 0 and the FSM is IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after one bit period.
  - DATA -> PARITY (if PARITY_EN) or STOP, after DATA_BITS periods.
  - PARITY -> STOP after one period.
  - STOP -> IDLE after STOP_BITS periods.
- Accept: a cycle with tx_valid=1 and tx_ready=1 (cycle T0).
  - tx_data is latched into the shift register.
  - From T0+1: tx_ready=0, busy=1, tx=0.
- Bit timing:
  - Each bit period is exactly div_cur clocks.
  - The baud counter runs 0..div_cur-1 and clears to 0 at accept.
  - A bit boundary occurs when the counter equals div_cur-1.
  - Data bit i (LSB first) drives tx during cycles T0+1+(1+i)*div_cur through T0+(2+i)*div_cur.
- Parity bit: XOR of the latched data, inverted when PARITY_ODD=1.
- Stop bits: tx=1.
- Frame length: N = 1 + DATA_BITS + PARITY_EN + STOP_BITS bit periods.
  - The last stop period ends at T0+N*div_cur.
  - At T0+N*div_cur+1: state is IDLE, busy=0, tx_ready=1, frame_done=1 for exactly one cycle.
- Back-to-back frames:
  - If tx_valid=1 in the first idle cycle, that cycle is the next accept and the next start bit begins the following cycle.
  - Minimum accept-to-accept spacing is N*div_cur+1 clocks.
  - tx stays high through that gap cycle.
- Divisor writes:
  - div_wr while IDLE (and not accepting in the same cycle): div_cur=max(div_val,2) on the next cycle.
  - div_wr while busy, or in the same cycle as an accept: the value is held pending. The running frame keeps the old divisor. The pending value is applied in the first idle cycle, before any accept in that cycle can start a frame.
  - The last write wins if several occur during a frame.
  - Values 0 and 1 clamp to 2.
- tx_valid low: no accept occurs. The sequencer does not require tx_data to stay stable after accept.
- tx is driven from a register (glitch-free output).

Test Plan:
1. Reset values: hold rst_n=0 then release -> tx=1, tx_ready=1, busy=0, frame_done=0, div_cur=434. Then div_wr with div_val=4 -> div_cur=4.
2. Single frame, div=4, tx_data=0xA5, no parity, 1 stop:
   - tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks from T0+1.
   - frame_done pulses at T0+41; tx_ready=1 at T0+41.
3. Back-to-back, div=4, tx_valid held high with 0x00 then 0xFF:
   - Second accept at T0+41; its start bit runs T0+42..T0+45.
   - tx=1 at T0+41.
   - Eight 0 bits then eight 1 bits observed.
4. Mid-frame divisor write: frame at div=4, div_wr div_val=8 during data bit 2:
   - Frame completes with 4-clock bits; div_cur=8 at the frame_done cycle.
   - Next frame uses 8-clock bits.
   - div_val=1 written while idle -> div_cur=2.
5. Parity, div=4, DATA_BITS=8:
   - PARITY_EN=1, PARITY_ODD=0, tx_data=0x07 -> parity bit 1, frame_done at T0+45.
   - PARITY_ODD=1, same data -> parity bit 0.
   - STOP_BITS=2 -> tx high 8 clocks before frame_done.
6. Reset mid-frame: rst_n=0 during data bit 3 ->
   - tx=1 and busy=0 immediately (asynchronous); no frame_done pulse.
   - After release: tx_ready=1, div_cur=DIV_RESET, and the next accepted frame is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//   Frame-level controller for the UART transmit path. It accepts one data word
//   per frame from the host over a valid/ready handshake. It then shifts out a
//   start bit, the data bits LSB first, an optional parity bit and the stop bits
//   on a registered, idle-high serial line. The baud divider is owned here. It
//   counts only while a frame is in flight. Its divisor can be reprogrammed at
//   runtime, but a running frame always finishes with the divisor it started
//   with.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_data     word to send, sampled on the accept cycle
//   tx_valid    tx_data is valid
//   tx_ready    idle, a word can be accepted this cycle
//   div_wr      one-cycle strobe to load div_val as the divisor
//   div_val     requested clocks per bit (0 and 1 clamp to 2)
//   div_cur     divisor currently in effect
//   tx          serial output, idle high
//   busy        frame in progress
//   frame_done  one-cycle pulse in the first idle cycle after a frame
module uart_tx_sequencer #(
   parameter int DATA_BITS  = 8,
   parameter int DIV_W      = 16,
   parameter int DIV_RESET  = 434,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 div_wr,
   input  logic [DIV_W-1:0]     div_val,
   output logic [DIV_W-1:0]     div_cur,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
   localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_RESET);
   localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     baud_q, baud_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [DIV_W-1:0]     pend_q, pend_d;
   logic                 pend_vld_q, pend_vld_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 accept;
   logic                 bit_end;

   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

   assign accept  = tx_valid && (state_q == S_IDLE);
   assign bit_end = (baud_q == (div_q - DIV_ONE));

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;

      // The baud counter only runs while a frame is in flight.
      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : (baud_q + DIV_ONE);
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_START;
               baud_d  = '0;
               shreg_d = tx_data;
               par_d   = parity_of(tx_data);
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shreg_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == LAST_DATA) begin
                  bit_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == LAST_STOP) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A divisor write lands immediately only when no frame is running or
      // starting. Otherwise it is parked, last write wins.
      if (div_wr) begin
         if ((state_q == S_IDLE) && !accept) begin
            div_d = clamp_div(div_val);
         end else begin
            pend_d     = clamp_div(div_val);
            pend_vld_d = 1'b1;
         end
      end

      // The parked value is committed on the edge that ends the frame. It is
      // therefore already in effect in the first idle cycle, so an accept in
      // that cycle starts the new frame with it.
      if ((state_q == S_STOP) && (state_d == S_IDLE)) begin
         if (div_wr) begin
            div_d = clamp_div(div_val);
         end else if (pend_vld_q) begin
            div_d = pend_q;
         end
         pend_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         div_q      <= DIV_RST;
         pend_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         div_q      <= div_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   // Payload registers are qualified by state / pend_vld and need no reset.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      pend_q  <= pend_d;
   end

   assign tx         = tx_q;
   assign tx_ready   = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign frame_done = done_q;
   assign div_cur    = div_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer
//   Three sequencer instances share the clock and reset:
//     [0] no parity, 1 stop
//     [1] even parity, 1 stop
//     [2] odd parity, 2 stops
//   The expected line levels for each frame are queued when the frame is
//   launched and popped once per bit period while the line is sampled on
//   every falling edge.
module tb_uart_tx_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  td [3];
   logic [2:0]  tx_valid;
   logic [2:0]  div_wr;
   logic [15:0] div_val;
   wire  [2:0]  tx_ready_w;
   wire  [2:0]  tx_w;
   wire  [2:0]  busy_w;
   wire  [2:0]  done_w;
   wire  [15:0] dc [3];

   int pe [3] = '{0, 1, 1};
   int po [3] = '{0, 0, 1};
   int sb [3] = '{1, 1, 2};

   int   vectors     = 0;
   int   miscompares = 0;
   logic exp_q [$];

   always #5 clk = ~clk;

   uart_tx_sequencer #(.DATA_BITS(8), .DIV_W(16), .DIV_RESET(434),
                       .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
      .clk(clk), .rst_n(rst_n), .tx_data(td[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready_w[0]), .div_wr(div_wr[0]), .div_val(div_val),
      .div_cur(dc[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

   uart_tx_sequencer #(.DATA_BITS(8), .DIV_W(16), .DIV_RESET(434),
                       .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_data(td[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready_w[1]), .div_wr(div_wr[1]), .div_val(div_val),
      .div_cur(dc[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

   uart_tx_sequencer #(.DATA_BITS(8), .DIV_W(16), .DIV_RESET(434),
                       .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd2 (
      .clk(clk), .rst_n(rst_n), .tx_data(td[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready_w[2]), .div_wr(div_wr[2]), .div_val(div_val),
      .div_cur(dc[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launch one frame on instance s at the current falling edge and follow it
   // cycle by cycle up to and including the frame_done cycle.
   //   keep=1  : leave tx_valid high and present nd right after the accept
   //   wr_k>=0 : pulse div_wr with wr_v during cycle T0+wr_k (0 = accept cycle)
   task automatic run_frame(input int s, input logic [7:0] d, input int div,
                            input bit keep, input logic [7:0] nd,
                            input int wr_k, input logic [15:0] wr_v,
                            input int div_after);
      int   n;
      logic e;
      n = 1 + 8 + pe[s] + sb[s];
      e = 1'b1;
      chk1("ready_before_accept", tx_ready_w[s], 1'b1);
      td[s]       = d;
      tx_valid[s] = 1'b1;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      if (pe[s] != 0) exp_q.push_back((^d) ^ (po[s] != 0));
      for (int i = 0; i < sb[s]; i++) exp_q.push_back(1'b1);
      if (wr_k == 0) begin
         div_wr[s] = 1'b1;
         div_val   = wr_v;
      end
      for (int k = 1; k <= n * div; k++) begin
         @(negedge clk);
         div_wr[s] = (k == wr_k);
         if (k == wr_k) div_val = wr_v;
         if (k == 1) begin
            if (keep) td[s] = nd;
            else tx_valid[s] = 1'b0;
         end
         if ((k - 1) % div == 0) e = exp_q.pop_front();
         chk1("tx_bit", tx_w[s], e);
         chk1("busy_in_frame", busy_w[s], 1'b1);
         chk1("ready_in_frame", tx_ready_w[s], 1'b0);
         chk1("done_in_frame", done_w[s], 1'b0);
         if (k == n * div) chk16("div_in_frame", dc[s], 16'(div));
      end
      @(negedge clk);
      div_wr[s] = 1'b0;
      chk1("frame_done", done_w[s], 1'b1);
      chk1("ready_after", tx_ready_w[s], 1'b1);
      chk1("busy_after", busy_w[s], 1'b0);
      chk1("tx_gap", tx_w[s], 1'b1);
      chk16("div_after", dc[s], 16'(div_after));
      chk16("queue_empty", 16'(exp_q.size()), 16'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = '0;
      div_wr   = '0;
      div_val  = '0;
      for (int s = 0; s < 3; s++) td[s] = '0;

      // Reset values, then program divisor 4 on all instances.
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         chk1("rst_tx", tx_w[s], 1'b1);
         chk1("rst_ready", tx_ready_w[s], 1'b1);
         chk1("rst_busy", busy_w[s], 1'b0);
         chk1("rst_done", done_w[s], 1'b0);
         chk16("rst_div", dc[s], 16'd434);
      end
      rst_n = 1'b1;
      @(negedge clk);
      div_wr  = 3'b111;
      div_val = 16'd4;
      @(negedge clk);
      div_wr = '0;
      for (int s = 0; s < 3; s++) chk16("div_idle_wr", dc[s], 16'd4);
      chk1("done_idle", done_w[0], 1'b0);

      // Single frame 0xA5.
      run_frame(0, 8'hA5, 4, 1'b0, 8'h00, -1, 16'd0, 4);
      @(negedge clk);
      chk1("done_one_cycle", done_w[0], 1'b0);
      chk1("tx_idle", tx_w[0], 1'b1);

      // Back-to-back with tx_valid held high.
      run_frame(0, 8'h00, 4, 1'b1, 8'hFF, -1, 16'd0, 4);
      run_frame(0, 8'hFF, 4, 1'b0, 8'h00, -1, 16'd0, 4);

      // Divisor write during data bit 2 stays pending until the frame ends;
      // the next frame, accepted in the first idle cycle, runs at 8.
      run_frame(0, 8'h5A, 4, 1'b0, 8'h00, 14, 16'd8, 8);
      run_frame(0, 8'hC3, 8, 1'b0, 8'h00, -1, 16'd0, 8);

      // Idle write of 1 clamps to 2.
      div_wr[0] = 1'b1;
      div_val   = 16'd1;
      @(negedge clk);
      div_wr[0] = 1'b0;
      chk16("div_clamp", dc[0], 16'd2);

      // Write in the accept cycle is deferred to the end of the frame.
      run_frame(0, 8'h96, 2, 1'b0, 8'h00, 0, 16'd4, 4);

      // Parity: even on 0x07 -> 1, odd -> 0 with two stop bits.
      run_frame(1, 8'h07, 4, 1'b0, 8'h00, -1, 16'd0, 4);
      run_frame(2, 8'h07, 4, 1'b0, 8'h00, -1, 16'd0, 4);

      // Asynchronous reset during data bit 3.
      @(negedge clk);
      td[0]       = 8'h00;
      tx_valid[0] = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 1) tx_valid[0] = 1'b0;
      end
      chk1("tx_bit3_before_rst", tx_w[0], 1'b0);
      chk1("busy_before_rst", busy_w[0], 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("async_rst_tx", tx_w[0], 1'b1);
      chk1("async_rst_busy", busy_w[0], 1'b0);
      chk1("async_rst_ready", tx_ready_w[0], 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1("no_done_in_rst", done_w[0], 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk1("ready_after_rst", tx_ready_w[0], 1'b1);
      chk1("done_after_rst", done_w[0], 1'b0);
      chk16("div_after_rst", dc[0], 16'd434);

      // Full frame at the reset divisor.
      run_frame(0, 8'h3C, 434, 1'b0, 8'h00, -1, 16'd0, 434);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
